// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES-over-UART datapath:
// clocking, block width, FSM encoding and GF(2^8) helpers.
package aes_uart_pkg;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD_RATE = 9600;
    localparam int DEF_CLOCK_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int BLOCK_W = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROUND2,
        S_ROUND1,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/decrypt_mid_inv_main_mid.sv
// Inverse of one middle cipher round: AddRoundKey, InvMixColumns,
// InvShiftRows, InvSubBytes. Purely combinational.
module inv_main_mid
    import aes_uart_pkg::*;
(
    input  logic [BLOCK_W-1:0] data,
    input  logic [BLOCK_W-1:0] key,
    output logic [BLOCK_W-1:0] result
);

    logic [BLOCK_W-1:0] keyed;
    logic [7:0] a [16];
    logic [7:0] m [16];
    logic [7:0] r [16];

    assign keyed = data ^ key;

    // Byte 0 is the MSB; state is column-major (byte 4*c+row)
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            a[i] = keyed[127-8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = gf_mul(a[4*c], 8'h0e) ^ gf_mul(a[4*c+1], 8'h0b)
                     ^ gf_mul(a[4*c+2], 8'h0d) ^ gf_mul(a[4*c+3], 8'h09);
            m[4*c+1] = gf_mul(a[4*c], 8'h09) ^ gf_mul(a[4*c+1], 8'h0e)
                     ^ gf_mul(a[4*c+2], 8'h0b) ^ gf_mul(a[4*c+3], 8'h0d);
            m[4*c+2] = gf_mul(a[4*c], 8'h0d) ^ gf_mul(a[4*c+1], 8'h09)
                     ^ gf_mul(a[4*c+2], 8'h0e) ^ gf_mul(a[4*c+3], 8'h0b);
            m[4*c+3] = gf_mul(a[4*c], 8'h0b) ^ gf_mul(a[4*c+1], 8'h0d)
                     ^ gf_mul(a[4*c+2], 8'h09) ^ gf_mul(a[4*c+3], 8'h0e);
        end
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[4*c+row] = INV_SBOX[m[4*((c - row + 4) % 4) + row]];
            end
        end
        result = '0;
        for (int i = 0; i < 16; i++) begin
            result[127-8*i -: 8] = r[i];
        end
    end

endmodule

// File: rtl/decrypt_mid.sv
// Two-round decryption stage between UART receive and transmit,
// with result timing paced in UART bit-times.
module decrypt_mid
    import aes_uart_pkg::*;
#(
    parameter int CLOCK_PER_BIT = DEF_CLOCK_PER_BIT,
    parameter int WAIT_BITS     = 159,
    parameter int HOLD_BITS     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] data,
    input  logic [BLOCK_W-1:0] key1,
    input  logic [BLOCK_W-1:0] key2,
    input  logic               data_state,
    output logic [BLOCK_W-1:0] decoded_data,
    output logic               decoded_state,
    output logic               busy
);

    localparam int MAX_BITS = (WAIT_BITS > HOLD_BITS) ? WAIT_BITS : HOLD_BITS;
    localparam int CW = $clog2(CLOCK_PER_BIT * MAX_BITS + 1);
    localparam logic [CW-1:0] WAIT_END = CW'(CLOCK_PER_BIT * WAIT_BITS - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(CLOCK_PER_BIT * HOLD_BITS - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [BLOCK_W-1:0] work;
    logic [BLOCK_W-1:0] round_key;
    logic [BLOCK_W-1:0] round_out;
    logic               capture;

    // key2 was the encryptor's last round, so it is peeled off first
    assign round_key = (state == S_ROUND2) ? key2 : key1;
    assign capture = data_state && (state == S_IDLE || state == S_HOLD);

    inv_main_mid u_inv (
        .data   (work),
        .key    (round_key),
        .result (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            work          <= '0;
            decoded_data  <= '0;
            decoded_state <= 1'b0;
            busy          <= 1'b0;
        end else if (capture) begin
            work          <= data;
            cnt           <= '0;
            state         <= S_ROUND2;
            decoded_state <= 1'b0;
            busy          <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt <= cnt;
                end
                S_ROUND2: begin
                    work  <= round_out;
                    cnt   <= cnt + 1'b1;
                    state <= S_ROUND1;
                end
                S_ROUND1: begin
                    work  <= round_out;
                    cnt   <= cnt + 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == WAIT_END) begin
                        decoded_data  <= work;
                        decoded_state <= 1'b1;
                        busy          <= 1'b0;
                        cnt           <= '0;
                        state         <= S_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_END) begin
                        decoded_state <= 1'b0;
                        cnt           <= '0;
                        state         <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
